// File: rtl/multiband_biquad_eq.sv
// multiband_biquad_eq: N-band time-multiplexed direct-form-I biquad equalizer with saturated mix
module multiband_biquad_eq #(
  parameter int NUM_BANDS = 3,
  parameter int W = 23,
  parameter int CW = 23,
  parameter int FRAC = 20,
  localparam int AW = $clog2(NUM_BANDS*5)
) (
  input  logic                   sclk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic signed [W-1:0]    uk,
  input  logic                   coef_we,
  input  logic [AW-1:0]          coef_addr,
  input  logic signed [CW-1:0]   coef_data,
  input  logic [NUM_BANDS-1:0]   band_mute,
  output logic [NUM_BANDS*W-1:0] yk_band,
  output logic signed [W-1:0]    yk_mix,
  output logic                   done,
  output logic                   busy,
  output logic                   overrun,
  output logic                   coef_err
);
  localparam int BW = NUM_BANDS > 1 ? $clog2(NUM_BANDS) : 1;
  localparam int ACW = W + CW + 3;
  localparam logic signed [ACW-1:0] MAXV = {{(ACW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACW-1:0] MINV = ~MAXV;
  typedef enum logic [1:0] {IDLE, MAC, STORE, MIX} state_t;
  state_t state;
  logic signed [CW-1:0] coef [NUM_BANDS*5];
  logic signed [W-1:0] yb [NUM_BANDS];
  logic signed [W-1:0] y1 [NUM_BANDS];
  logic signed [W-1:0] y2 [NUM_BANDS];
  logic signed [W-1:0] u0, u1, u2, op, res, mix;
  logic signed [W+CW-1:0] prod;
  logic signed [ACW-1:0] acc, term, acc_n;
  logic signed [W+2:0] sum;
  logic [BW-1:0] band;
  logic [2:0] tap;
  logic [AW-1:0] idx;
  logic last;
  function automatic logic signed [W-1:0] sat(input logic signed [ACW-1:0] v);
    return v > MAXV ? MAXV[W-1:0] : v < MINV ? MINV[W-1:0] : v[W-1:0];
  endfunction
  for (genvar g = 0; g < NUM_BANDS; g++) begin : g_out
    assign yk_band[g*W +: W] = yb[g];
  end
  always_comb begin
    idx = AW'(int'(band)*5 + int'(tap));
    last = band == BW'(NUM_BANDS-1);
    op = tap == 3'd0 ? u0 : tap == 3'd1 ? u1 : tap == 3'd2 ? u2 : tap == 3'd3 ? y1[band] : y2[band];
    prod = coef[idx] * op;
    term = prod;
    term = tap > 3'd2 ? -term : term;
    acc_n = tap == 3'd0 ? term : acc + term;
    res = sat(acc >>> FRAC);
    sum = '0;
    for (int i = 0; i < NUM_BANDS; i++) sum = band_mute[i] ? sum : sum + yb[i];
    mix = sat(sum);
  end
  always_ff @(posedge sclk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      overrun <= 1'b0;
      coef_err <= 1'b0;
      yk_mix <= '0;
      u0 <= '0;
      u1 <= '0;
      u2 <= '0;
      acc <= '0;
      band <= '0;
      tap <= '0;
      for (int i = 0; i < NUM_BANDS*5; i++) coef[i] <= '0;
      for (int i = 0; i < NUM_BANDS; i++) begin
        yb[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      coef_err <= coef_we && busy;
      overrun <= overrun | (enable && busy);
      if (coef_we && !busy && int'(coef_addr) < NUM_BANDS*5) coef[coef_addr] <= coef_data;
      case (state)
        IDLE: if (enable) begin
          u0 <= uk;
          busy <= 1'b1;
          band <= '0;
          tap <= '0;
          state <= MAC;
        end
        MAC: begin
          acc <= acc_n;
          tap <= tap + 3'd1;
          state <= tap == 3'd4 ? STORE : MAC;
        end
        STORE: begin
          yb[band] <= res;
          y1[band] <= res;
          y2[band] <= y1[band];
          tap <= '0;
          band <= last ? band : band + BW'(1);
          state <= last ? MIX : MAC;
        end
        default: begin
          yk_mix <= mix;
          u2 <= u1;
          u1 <= u0;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multiband_biquad_eq.sv
// tb_multiband_biquad_eq: table-driven directed checks of the N-band biquad equalizer
module tb_multiband_biquad_eq;
  localparam int NB = 3;
  localparam int W = 23;
  localparam int CW = 23;
  localparam int AW = 4;
  logic sclk = 1'b0;
  logic rst, enable, coef_we, done, busy, overrun, coef_err;
  logic signed [W-1:0] uk, yk_mix;
  logic [AW-1:0] coef_addr;
  logic signed [CW-1:0] coef_data;
  logic [NB-1:0] band_mute;
  logic [NB*W-1:0] yk_band;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    int op;
    int a;
    int v;
    logic [2:0] m;
    int e0;
    int e1;
    int e2;
    int em;
  } vec_t;
  vec_t vt[$];
  always #5 sclk = ~sclk;
  multiband_biquad_eq #(.NUM_BANDS(NB), .W(W), .CW(CW), .FRAC(20)) dut (
    .sclk(sclk), .rst(rst), .enable(enable), .uk(uk), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .band_mute(band_mute),
    .yk_band(yk_band), .yk_mix(yk_mix), .done(done), .busy(busy),
    .overrun(overrun), .coef_err(coef_err)
  );
  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  function automatic int yb(int i);
    logic signed [W-1:0] t;
    t = yk_band[i*W +: W];
    return int'(t);
  endfunction
  task automatic tick();
    @(posedge sclk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  task automatic wcoef(int a, int v);
    coef_we = 1'b1;
    coef_addr = AW'(a);
    coef_data = CW'(v);
    tick();
    coef_we = 1'b0;
    chk("coef_err_idle", int'(coef_err), 0);
  endtask
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
  endtask
  task automatic run(int u, logic [2:0] m, output int lat, output int bsy);
    enable = 1'b1;
    uk = W'(u);
    band_mute = m;
    tick();
    enable = 1'b0;
    coef_we = 1'b0;
    bsy = int'(busy);
    lat = 0;
    do begin
      tick();
      lat++;
      bsy += int'(busy);
    end while (!done && lat < 100);
  endtask
  initial begin
    int lat, bsy, nd;
    rst = 1'b1;
    enable = 1'b0;
    uk = '0;
    coef_we = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    band_mute = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_coef_err", int'(coef_err), 0);
    chk("rst_mix", int'(yk_mix), 0);
    chk("rst_bands", int'(yk_band != '0), 0);
    vt.push_back('{0, 0, 0, 3'b000, 0, 0, 0, 0});
    vt.push_back('{1, 15, 1048576, 3'b000, 0, 0, 0, 0});
    vt.push_back('{2, 0, 1000, 3'b000, 0, 0, 0, 0});
    vt.push_back('{0, 0, 0, 3'b000, 0, 0, 0, 0});
    vt.push_back('{1, 0, 1048576, 3'b000, 0, 0, 0, 0});
    vt.push_back('{2, 0, 1000, 3'b000, 1000, 0, 0, 1000});
    vt.push_back('{2, 0, 1000, 3'b001, 1000, 0, 0, 0});
    vt.push_back('{0, 0, 0, 3'b000, 0, 0, 0, 0});
    vt.push_back('{1, 6, 524288, 3'b000, 0, 0, 0, 0});
    vt.push_back('{2, 0, 4000, 3'b000, 0, 0, 0, 0});
    vt.push_back('{2, 0, 0, 3'b000, 0, 2000, 0, 2000});
    vt.push_back('{2, 0, 0, 3'b000, 0, 0, 0, 0});
    vt.push_back('{0, 0, 0, 3'b000, 0, 0, 0, 0});
    vt.push_back('{1, 10, 1048576, 3'b000, 0, 0, 0, 0});
    vt.push_back('{1, 13, -524288, 3'b000, 0, 0, 0, 0});
    vt.push_back('{2, 0, 1024, 3'b000, 0, 0, 1024, 1024});
    vt.push_back('{2, 0, 0, 3'b000, 0, 0, 512, 512});
    vt.push_back('{2, 0, 0, 3'b000, 0, 0, 256, 256});
    vt.push_back('{2, 0, 0, 3'b000, 0, 0, 128, 128});
    vt.push_back('{0, 0, 0, 3'b000, 0, 0, 0, 0});
    vt.push_back('{1, 0, 1048576, 3'b000, 0, 0, 0, 0});
    vt.push_back('{1, 5, 1048576, 3'b000, 0, 0, 0, 0});
    vt.push_back('{2, 0, 4194303, 3'b000, 4194303, 4194303, 0, 4194303});
    vt.push_back('{2, 0, -4194304, 3'b000, -4194304, -4194304, 0, -4194304});
    vt.push_back('{1, 0, 2097152, 3'b000, 0, 0, 0, 0});
    vt.push_back('{2, 0, 3000000, 3'b000, 4194303, 3000000, 0, 4194303});
    foreach (vt[i]) begin
      if (vt[i].op == 0) do_reset();
      else if (vt[i].op == 1) wcoef(vt[i].a, vt[i].v);
      else begin
        run(vt[i].v, vt[i].m, lat, bsy);
        chk($sformatf("v%0d_latency", i), lat, 19);
        chk($sformatf("v%0d_busy_cycles", i), bsy, 19);
        chk($sformatf("v%0d_band0", i), yb(0), vt[i].e0);
        chk($sformatf("v%0d_band1", i), yb(1), vt[i].e1);
        chk($sformatf("v%0d_band2", i), yb(2), vt[i].e2);
        chk($sformatf("v%0d_mix", i), int'(yk_mix), vt[i].em);
      end
    end
    do_reset();
    wcoef(0, 1048576);
    enable = 1'b1;
    uk = W'(500);
    band_mute = '0;
    tick();
    enable = 1'b0;
    repeat (4) tick();
    enable = 1'b1;
    uk = W'(9999);
    tick();
    enable = 1'b0;
    chk("overrun_set", int'(overrun), 1);
    nd = 0;
    repeat (40) begin
      tick();
      nd += int'(done);
    end
    chk("overrun_done_count", nd, 1);
    chk("overrun_band0", yb(0), 500);
    chk("overrun_sticky", int'(overrun), 1);
    enable = 1'b1;
    uk = W'(600);
    tick();
    enable = 1'b0;
    tick();
    tick();
    coef_we = 1'b1;
    coef_addr = '0;
    coef_data = '0;
    tick();
    coef_we = 1'b0;
    chk("coef_err_pulse", int'(coef_err), 1);
    tick();
    chk("coef_err_clear", int'(coef_err), 0);
    wait_done(lat);
    chk("busy_write_done", int'(done), 1);
    run(700, 3'b000, lat, bsy);
    chk("coef_kept_band0", yb(0), 700);
    enable = 1'b1;
    uk = W'(700);
    tick();
    enable = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    nd = 0;
    repeat (30) begin
      tick();
      nd += int'(done);
    end
    chk("midrst_no_done", nd, 0);
    run(700, 3'b000, lat, bsy);
    chk("midrst_latency", lat, 19);
    chk("midrst_band0", yb(0), 0);
    chk("midrst_mix", int'(yk_mix), 0);
    coef_we = 1'b1;
    coef_addr = '0;
    coef_data = CW'(1048576);
    run(321, 3'b000, lat, bsy);
    chk("same_cycle_band0", yb(0), 321);
    chk("same_cycle_mix", int'(yk_mix), 321);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
